// File: rtl/instr_fetch_buffer_if.sv
// Fetch-side bundle between the PC block, instruction memory and decode.
// Handshakes: a transfer happens on a cycle where valid and ready are both 1; valid may not depend on ready.
interface instr_fetch_buffer_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] pc_i;
    logic              pc_valid_i;
    logic              pc_ready_o;
    logic              flush_i;
    logic              imem_req_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic              imem_rvalid_i;
    logic [DATA_W-1:0] imem_rdata_i;
    logic [DATA_W-1:0] inst_o;
    logic [ADDR_W-1:0] inst_pc_o;
    logic              inst_valid_o;
    logic              inst_ready_i;
    logic [CNT_W-1:0]  count_o;
    logic              proto_err_o;

    modport slave (
        input  pc_i, pc_valid_i, flush_i, imem_rvalid_i, imem_rdata_i, inst_ready_i,
        output pc_ready_o, imem_req_o, imem_addr_o, inst_o, inst_pc_o, inst_valid_o,
               count_o, proto_err_o
    );

    modport master (
        output pc_i, pc_valid_i, flush_i, imem_rvalid_i, imem_rdata_i, inst_ready_i,
        input  pc_ready_o, imem_req_o, imem_addr_o, inst_o, inst_pc_o, inst_valid_o,
               count_o, proto_err_o
    );
endinterface

// File: rtl/instr_fetch_buffer.sv
// In-order instruction fetch buffer: one entry is allocated per memory request and filled
// by the in-order response; a redirect flushes the entries and drops responses still in flight.
module instr_fetch_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic clk_i,
    input logic rst_ni,
    instr_fetch_buffer_if.slave bus
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int DROP_W = PTR_W + 2;

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0]  filled;
    logic [PTR_W-1:0]  alloc_ptr;
    logic [PTR_W-1:0]  fill_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  pend_cnt;
    logic [DROP_W-1:0] drop_cnt;
    logic              proto_err;

    logic head_valid;
    logic pop;
    logic ready;
    logic issue;
    logic resp_drop;
    logic resp_fill;
    logic resp_err;

    assign head_valid = filled[rd_ptr] && (count != '0) && !bus.flush_i;
    assign pop        = head_valid && bus.inst_ready_i;
    assign ready      = !bus.flush_i && ((count < CNT_W'(DEPTH)) || pop);
    assign issue      = bus.pc_valid_i && ready;

    // A response first pays off pending drops, then fills the oldest outstanding entry.
    assign resp_drop = bus.imem_rvalid_i && (drop_cnt != '0);
    assign resp_fill = bus.imem_rvalid_i && (drop_cnt == '0) && (pend_cnt != '0);
    assign resp_err  = bus.imem_rvalid_i && (drop_cnt == '0) && (pend_cnt == '0);

    assign bus.pc_ready_o   = ready;
    assign bus.imem_req_o   = issue;
    assign bus.imem_addr_o  = {bus.pc_i[ADDR_W-1:2], 2'b00};
    assign bus.inst_o       = data_mem[rd_ptr];
    assign bus.inst_pc_o    = pc_mem[rd_ptr];
    assign bus.inst_valid_o = head_valid;
    assign bus.count_o      = count;
    assign bus.proto_err_o  = proto_err;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            pend_cnt  <= '0;
            drop_cnt  <= '0;
            filled    <= '0;
            proto_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                data_mem[i] <= '0;
            end
        end else if (bus.flush_i) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            pend_cnt  <= '0;
            filled    <= '0;
            // Everything still outstanding becomes a drop; a coincident response is one of them.
            drop_cnt  <= drop_cnt + DROP_W'(pend_cnt) - DROP_W'(resp_drop || resp_fill);
            if (resp_err) proto_err <= 1'b1;
        end else begin
            if (resp_drop) drop_cnt <= drop_cnt - DROP_W'(1);
            if (resp_err)  proto_err <= 1'b1;
            if (resp_fill) begin
                data_mem[fill_ptr] <= bus.imem_rdata_i;
                filled[fill_ptr]   <= 1'b1;
                fill_ptr           <= fill_ptr + PTR_W'(1);
            end
            if (pop) begin
                filled[rd_ptr] <= 1'b0;
                rd_ptr         <= rd_ptr + PTR_W'(1);
            end
            // When full, the issued slot is the one being popped this cycle.
            if (issue) begin
                pc_mem[alloc_ptr] <= bus.pc_i;
                filled[alloc_ptr] <= 1'b0;
                alloc_ptr         <= alloc_ptr + PTR_W'(1);
            end
            count    <= count + CNT_W'(issue) - CNT_W'(pop);
            pend_cnt <= pend_cnt + CNT_W'(issue) - CNT_W'(resp_fill);
        end
    end
endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Bench for instr_fetch_buffer: in-order memory model with per-request latency, queue-based
// reference of the buffer contents, directed scenarios followed by a randomized stretch.
module tb_instr_fetch_buffer;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        bit          filled;
    } entry_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } mem_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    instr_fetch_buffer_if #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) bus ();

    instr_fetch_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    entry_t exp_q[$];
    mem_t   mem_q[$];
    int     pop_log[$];
    int     m_drop = 0;
    bit     m_err = 0;
    int     cyc = 0;
    int     last_due = 0;
    int     mem_lat = 1;

    logic        s_valid, s_ready, s_req, s_err;
    logic [31:0] s_inst, s_pc, s_addr;
    logic [2:0]  s_count;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock cycle: check outputs at the falling edge, then advance model and memory.
    task automatic cycle();
        bit e_valid, e_ready, e_req, found;
        int unf, due;
        #4;
        e_valid = !bus.flush_i && (exp_q.size() > 0) && exp_q[0].filled;
        e_ready = !bus.flush_i && ((exp_q.size() < DEPTH) || (e_valid && bus.inst_ready_i));
        e_req   = bus.pc_valid_i && e_ready;
        s_valid = bus.inst_valid_o;
        s_ready = bus.pc_ready_o;
        s_req   = bus.imem_req_o;
        s_err   = bus.proto_err_o;
        s_inst  = bus.inst_o;
        s_pc    = bus.inst_pc_o;
        s_addr  = bus.imem_addr_o;
        s_count = bus.count_o;
        chk("count", 32'(s_count), 32'(exp_q.size()));
        chk("inst_valid", 32'(s_valid), 32'(e_valid));
        chk("pc_ready", 32'(s_ready), 32'(e_ready));
        chk("imem_req", 32'(s_req), 32'(e_req));
        chk("proto_err", 32'(s_err), 32'(m_err));
        if (e_req) chk("imem_addr", s_addr, bus.pc_i & 32'hFFFF_FFFC);
        if (e_valid) begin
            chk("inst", s_inst, exp_q[0].data);
            chk("inst_pc", s_pc, exp_q[0].pc);
        end
        if (s_valid && bus.inst_ready_i) pop_log.push_back(cyc);
        @(posedge clk);
        if (bus.imem_rvalid_i) begin
            if (m_drop > 0) m_drop--;
            else begin
                found = 0;
                foreach (exp_q[i]) begin
                    if (!found && !exp_q[i].filled) begin
                        exp_q[i].data   = bus.imem_rdata_i;
                        exp_q[i].filled = 1;
                        found = 1;
                    end
                end
                if (!found) m_err = 1;
            end
        end
        if (bus.flush_i) begin
            unf = 0;
            foreach (exp_q[i]) if (!exp_q[i].filled) unf++;
            m_drop += unf;
            exp_q.delete();
        end else begin
            if (e_valid && bus.inst_ready_i) void'(exp_q.pop_front());
            if (e_req) exp_q.push_back('{pc: bus.pc_i, data: 32'h0, filled: 0});
        end
        if (s_req) begin
            due = cyc + mem_lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mem_q.push_back('{due: due, data: $urandom});
        end
        cyc++;
        #1;
        if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
            bus.imem_rvalid_i = 1'b1;
            bus.imem_rdata_i  = mem_q[0].data;
            void'(mem_q.pop_front());
        end else begin
            bus.imem_rvalid_i = 1'b0;
            bus.imem_rdata_i  = $urandom;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.pc_valid_i    = 1'b0;
        bus.pc_i          = 32'h0;
        bus.flush_i       = 1'b0;
        bus.inst_ready_i  = 1'b0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = 32'h0;
        repeat (2) @(posedge clk);
        exp_q.delete();
        mem_q.delete();
        m_drop = 0;
        m_err = 0;
        last_due = cyc;
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (!s_valid && n < 30);
        chk(tag, 32'(s_valid), 32'd1);
    endtask

    task automatic check_reset_state(input string tag);
        cycle();
        chk({tag, "_valid"}, 32'(s_valid), 32'd0);
        chk({tag, "_count"}, 32'(s_count), 32'd0);
        chk({tag, "_ready"}, 32'(s_ready), 32'd1);
        chk({tag, "_err"}, 32'(s_err), 32'd0);
        chk({tag, "_req"}, 32'(s_req), 32'd0);
        chk({tag, "_inst"}, s_inst, 32'd0);
        chk({tag, "_pc"}, s_pc, 32'd0);
    endtask

    initial begin
        logic [31:0] pc;

        // Power-on reset
        do_reset();
        check_reset_state("rst0");

        // Stream of four fetches, latency 1, decode always ready
        mem_lat = 1;
        bus.inst_ready_i = 1'b1;
        pop_log.delete();
        for (int k = 0; k < 4; k++) begin
            bus.pc_valid_i = 1'b1;
            bus.pc_i = 32'(k * 4);
            cycle();
        end
        bus.pc_valid_i = 1'b0;
        repeat (4) cycle();
        chk("stream_pops", 32'(pop_log.size()), 32'd4);
        if (pop_log.size() == 4) chk("stream_rate", 32'(pop_log[3] - pop_log[0]), 32'd3);

        // Backpressure: decode stalled until the buffer fills
        bus.inst_ready_i = 1'b0;
        bus.pc_valid_i = 1'b1;
        pc = 32'h0000_1000;
        bus.pc_i = pc;
        for (int k = 0; k < 6; k++) begin
            cycle();
            if (s_req) begin
                pc += 4;
                bus.pc_i = pc;
            end
        end
        chk("bp_ready", 32'(s_ready), 32'd0);
        chk("bp_req", 32'(s_req), 32'd0);
        chk("bp_count", 32'(s_count), 32'd4);
        bus.inst_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("bp_full_count", 32'(s_count), 32'd4);
            chk("bp_full_req", 32'(s_req), 32'd1);
            if (s_req) begin
                pc += 4;
                bus.pc_i = pc;
            end
        end
        bus.pc_valid_i = 1'b0;
        repeat (8) cycle();

        // Flush with two requests outstanding, latency 3
        mem_lat = 3;
        bus.pc_valid_i = 1'b1;
        bus.pc_i = 32'h0000_0100;
        cycle();
        bus.pc_i = 32'h0000_0104;
        cycle();
        bus.pc_valid_i = 1'b0;
        bus.flush_i = 1'b1;
        cycle();
        bus.flush_i = 1'b0;
        bus.pc_valid_i = 1'b1;
        bus.pc_i = 32'h1234_5600;
        cycle();
        bus.pc_valid_i = 1'b0;
        wait_valid("flush_wait");
        chk("flush_first_pc", s_pc, 32'h1234_5600);
        chk("flush_err", 32'(s_err), 32'd0);
        repeat (3) cycle();

        // Flush coincident with the first of three responses
        for (int k = 0; k < 3; k++) begin
            bus.pc_valid_i = 1'b1;
            bus.pc_i = 32'h0000_0200 + 32'(k * 4);
            cycle();
        end
        bus.pc_valid_i = 1'b0;
        chk("coinc_rvalid_aligned", 32'(bus.imem_rvalid_i), 32'd1);
        bus.flush_i = 1'b1;
        cycle();
        bus.flush_i = 1'b0;
        bus.pc_valid_i = 1'b1;
        bus.pc_i = 32'h0000_0300;
        cycle();
        bus.pc_valid_i = 1'b0;
        wait_valid("coinc_wait");
        chk("coinc_first_pc", s_pc, 32'h0000_0300);
        repeat (6) cycle();
        chk("coinc_err", 32'(s_err), 32'd0);
        chk("coinc_count", 32'(s_count), 32'd0);

        // Randomized traffic: PC holds its request while not accepted
        bus.pc_valid_i = 1'b0;
        for (int k = 0; k < 400; k++) begin
            mem_lat = $urandom_range(1, 4);
            if (!bus.pc_valid_i || s_req || bus.flush_i) begin
                bus.pc_valid_i = ($urandom_range(0, 3) != 0);
                bus.pc_i = $urandom;
            end
            bus.flush_i = ($urandom_range(0, 15) == 0);
            bus.inst_ready_i = ($urandom_range(0, 3) != 0);
            cycle();
        end

        // Reset in the middle of traffic
        bus.pc_valid_i = 1'b1;
        bus.pc_i = 32'h0000_0400;
        bus.flush_i = 1'b0;
        bus.inst_ready_i = 1'b0;
        cycle();
        cycle();
        do_reset();
        check_reset_state("rst_mid");

        // Spurious response with nothing outstanding, then a misaligned fetch
        mem_lat = 1;
        bus.inst_ready_i = 1'b1;
        cycle();
        bus.imem_rvalid_i = 1'b1;
        bus.imem_rdata_i = 32'hDEAD_BEEF;
        cycle();
        cycle();
        chk("spur_err", 32'(s_err), 32'd1);
        bus.pc_valid_i = 1'b1;
        bus.pc_i = 32'h8765_4302;
        cycle();
        chk("spur_req", 32'(s_req), 32'd1);
        chk("spur_addr", s_addr, 32'h8765_4300);
        bus.pc_valid_i = 1'b0;
        wait_valid("spur_wait");
        chk("spur_inst_pc", s_pc, 32'h8765_4302);
        chk("spur_err_sticky", 32'(s_err), 32'd1);
        repeat (3) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
